// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receive path.
//   PS2_EXT / PS2_BRK : prefix bytes folded into key events
//   frame_state_t     : frame receiver state encoding
//   key_event_t       : FIFO entry layout {release, extended, code}
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam int EVENT_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } frame_state_t;

   // Bit 9 = release (F0 seen), bit 8 = extended (E0 seen), bits 7:0 = code
   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: small synchronous FIFO holding decoded key events.
//   clk      : system clock (rising edge)
//   rst      : synchronous active-low reset
//   push     : write din this cycle
//   pop      : consume head this cycle (ignored when empty)
//   din      : event to write
//   head     : current head entry, 0 when empty
//   full     : DEPTH entries stored
//   empty    : no entries stored
//   overflow : sticky, a push was dropped because the FIFO was full
module key_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [EVENT_WIDTH-1:0] din,
   output logic [EVENT_WIDTH-1:0] head,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [EVENT_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count;
   logic                   do_push;
   logic                   do_pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A pop on a full FIFO frees the slot the same cycle, so a simultaneous push is accepted
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head = empty ? '0 : mem[rd_ptr];

   // Pointer, occupancy and sticky overflow bookkeeping
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   // Storage needs no reset; head is masked to 0 while empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver with prefix folding and event FIFO.
//   Clk          : system clock (rising edge)
//   Rst          : synchronous active-low reset
//   clk_kb       : raw PS/2 clock, asynchronous
//   data_kb      : raw PS/2 data, asynchronous
//   pop          : one-cycle strobe consuming the head event
//   key_valid    : event FIFO not empty
//   KeyCode      : head scan code (0 when empty)
//   key_release  : head event had an F0 prefix (0 when empty)
//   key_extended : head event had an E0 prefix (0 when empty)
//   overflow     : sticky, an event was dropped on a full FIFO
//   frame_err    : one-cycle pulse on parity, stop or timeout error
module ps2_key_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       clk_kb,
   input  logic       data_kb,
   input  logic       pop,
   output logic       key_valid,
   output logic [7:0] KeyCode,
   output logic       key_release,
   output logic       key_extended,
   output logic       overflow,
   output logic       frame_err
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic             clk_s1, clk_s2, clk_prev;
   logic             data_s1, data_s2;
   logic             fall;
   frame_state_t     state, next_state;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift;
   logic             parity_bit;
   logic [WD_W-1:0]  wd_cnt;
   logic             timeout;
   logic             stop_ok;
   logic             err_now;
   logic             valid_q;
   logic [7:0]       byte_q;
   logic             ext_flag, brk_flag;
   logic             push_evt;
   key_event_t       new_evt;
   logic [EVENT_WIDTH-1:0] head;
   logic             fifo_empty;

   // Two-flop synchronizers plus a history flop for edge detection; idle line level is 1
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
      end else begin
         clk_s1   <= clk_kb;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= data_kb;
         data_s2  <= data_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   // Watchdog only runs mid-frame; any falling edge restarts it
   assign timeout = (state != IDLE) && !fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         wd_cnt <= '0;
      end else if (state == IDLE || fall || timeout) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // Frame FSM state register
   always_ff @(posedge Clk) begin
      if (!Rst) state <= IDLE;
      else      state <= next_state;
   end

   // Frame FSM next-state logic; a start bit of 1 is a spurious edge and is ignored
   always_comb begin
      next_state = state;
      if (timeout) begin
         next_state = IDLE;
      end else if (fall) begin
         unique case (state)
            IDLE:    if (!data_s2) next_state = DATA;
            DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
            PARITY:  next_state = STOP;
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Frame FSM outputs: stop-bit verdict and error strobe
   always_comb begin
      stop_ok = 1'b0;
      err_now = timeout;
      if (fall && state == STOP) begin
         if (data_s2 && (^{shift, parity_bit})) stop_ok = 1'b1;
         else                                   err_now = 1'b1;
      end
   end

   // Frame datapath: data bits arrive LSB first, so shift in from the top
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         bit_cnt    <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
      end else if (fall) begin
         case (state)
            IDLE:    bit_cnt <= '0;
            DATA: begin
               shift   <= {data_s2, shift[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
            PARITY:  parity_bit <= data_s2;
            default: ;
         endcase
      end
   end

   // Validated byte is registered, then decoded one cycle later
   assign push_evt = valid_q && (byte_q != PS2_EXT) && (byte_q != PS2_BRK);
   assign new_evt  = '{brk: brk_flag, ext: ext_flag, code: byte_q};

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         valid_q   <= 1'b0;
         byte_q    <= '0;
         ext_flag  <= 1'b0;
         brk_flag  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid_q   <= stop_ok;
         if (stop_ok) byte_q <= shift;
         frame_err <= err_now;
         if (err_now) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
         end else if (valid_q) begin
            if (byte_q == PS2_EXT) begin
               ext_flag <= 1'b1;
            end else if (byte_q == PS2_BRK) begin
               brk_flag <= 1'b1;
            end else begin
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
            end
         end
      end
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (Clk),
      .rst      (Rst),
      .push     (push_evt),
      .pop      (pop),
      .din      (new_evt),
      .head     (head),
      .full     (),
      .empty    (fifo_empty),
      .overflow (overflow)
   );

   assign key_valid    = ~fifo_empty;
   assign key_release  = head[9];
   assign key_extended = head[8];
   assign KeyCode      = head[7:0];

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: self-checking bench for ps2_key_rx.
// Frames are bit-banged on clk_kb/data_kb; a queue-based reference model
// tracks prefixes, the event FIFO contents and the sticky overflow flag.
module tb_ps2_key_rx;

   localparam int DEPTH   = 4;
   localparam int TB_TO   = 300;
   localparam int HALF    = 8;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       clk_kb = 1'b1;
   logic       data_kb = 1'b1;
   logic       pop = 1'b0;
   logic       key_valid;
   logic [7:0] KeyCode;
   logic       key_release;
   logic       key_extended;
   logic       overflow;
   logic       frame_err;

   int compared   = 0;
   int mismatched = 0;
   int err_cycles = 0;

   logic [9:0] mq[$];
   bit         m_ext = 0;
   bit         m_brk = 0;
   bit         m_ovf = 0;

   ps2_key_rx #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TB_TO)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .clk_kb       (clk_kb),
      .data_kb      (data_kb),
      .pop          (pop),
      .key_valid    (key_valid),
      .KeyCode      (KeyCode),
      .key_release  (key_release),
      .key_extended (key_extended),
      .overflow     (overflow),
      .frame_err    (frame_err)
   );

   // 10 ns system clock
   always #5 Clk = ~Clk;

   // Count every cycle frame_err is high so pulse widths can be checked
   always @(negedge Clk) begin
      if (frame_err === 1'b1) err_cycles++;
   end

   // Overall time limit so the bench can never hang
   initial begin
      #800000;
      $display("[TB] FAIL global_timeout: simulation time limit reached, expected completion");
      $fatal(1, "[TB] time limit");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   // Reference model: apply one received frame at the key-event level
   task automatic model_frame(input logic [7:0] b, input bit good);
      if (!good) begin
         m_ext = 0;
         m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         if (mq.size() < DEPTH) mq.push_back({m_brk, m_ext, b});
         else                   m_ovf = 1;
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ext = 0;
      m_brk = 0;
      m_ovf = 0;
   endtask

   // Expected {key_valid, key_release, key_extended, KeyCode}
   function automatic logic [10:0] exp_head();
      if (mq.size() != 0) return {1'b1, mq[0]};
      return 11'd0;
   endfunction

   // Drive one PS/2 frame (nbits < 11 truncates it). pop_on_push raises pop in the
   // cycle the byte is written to the FIFO; chk_lat checks key_valid around that write.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, input bit pop_on_push, input bit chk_lat);
      logic [10:0] fr;
      fr[0]   = 1'b0;
      fr[8:1] = b;
      fr[9]   = (~^b) ^ bad_par;
      fr[10]  = ~bad_stop;
      for (int i = 0; i < nbits; i++) begin
         data_kb = fr[i];
         wait_cycles(HALF);
         clk_kb = 1'b0;
         if (i == 10) begin
            wait_cycles(3);
            if (chk_lat) begin
               compared++;
               if (key_valid !== 1'b0) begin
                  mismatched++;
                  $display("[TB] FAIL latency_n1: key_valid=%b expected 0", key_valid);
               end
            end
            if (pop_on_push) pop = 1'b1;
            tick();
            pop = 1'b0;
            if (chk_lat) begin
               compared++;
               if (key_valid !== 1'b1) begin
                  mismatched++;
                  $display("[TB] FAIL latency_n2: key_valid=%b expected 1", key_valid);
               end
            end
            wait_cycles(HALF - 4);
         end else begin
            wait_cycles(HALF);
         end
         clk_kb = 1'b1;
      end
      data_kb = 1'b1;
      wait_cycles(2 * HALF);
   endtask

   task automatic do_pop();
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tick();
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic test_reset();
      Rst = 1'b0;
      wait_cycles(2);
      compared++;
      if ({key_valid, KeyCode, key_release, key_extended, overflow, frame_err} !== 13'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got %b expected all 0",
                  {key_valid, KeyCode, key_release, key_extended, overflow, frame_err});
      end
      Rst = 1'b1;
      model_reset();
      wait_cycles(2);
   endtask

   task automatic test_basic();
      int e0 = err_cycles;
      send_frame(8'h1C, 0, 0, 11, 0, 1);
      model_frame(8'h1C, 1);
      compared++;
      if ({key_valid, key_release, key_extended, KeyCode} !== exp_head()) begin
         mismatched++;
         $display("[TB] FAIL basic_head: got %h expected %h",
                  {key_valid, key_release, key_extended, KeyCode}, exp_head());
      end
      compared++;
      if (err_cycles - e0 !== 0) begin
         mismatched++;
         $display("[TB] FAIL basic_no_err: frame_err cycles %0d expected 0", err_cycles - e0);
      end
      do_pop();
      compared++;
      if ({key_valid, key_release, key_extended, KeyCode} !== 11'd0) begin
         mismatched++;
         $display("[TB] FAIL basic_popped: got %h expected 000",
                  {key_valid, key_release, key_extended, KeyCode});
      end
   endtask

   task automatic test_break();
      send_frame(8'hF0, 0, 0, 11, 0, 0);
      model_frame(8'hF0, 1);
      compared++;
      if (key_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL break_prefix_no_event: key_valid=%b expected 0", key_valid);
      end
      send_frame(8'h1C, 0, 0, 11, 0, 0);
      model_frame(8'h1C, 1);
      compared++;
      if ({key_valid, key_release, key_extended, KeyCode} !== exp_head()) begin
         mismatched++;
         $display("[TB] FAIL break_head: got %h expected %h",
                  {key_valid, key_release, key_extended, KeyCode}, exp_head());
      end
      do_pop();
      compared++;
      if (key_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL break_single_event: key_valid=%b expected 0", key_valid);
      end
   endtask

   task automatic test_ext_break();
      logic [7:0] seq [4] = '{8'hE0, 8'hF0, 8'h75, 8'h74};
      for (int i = 0; i < 4; i++) begin
         send_frame(seq[i], 0, 0, 11, 0, 0);
         model_frame(seq[i], 1);
         if (i >= 2) begin
            compared++;
            if ({key_valid, key_release, key_extended, KeyCode} !== exp_head()) begin
               mismatched++;
               $display("[TB] FAIL ext_break_head_%0d: got %h expected %h", i,
                        {key_valid, key_release, key_extended, KeyCode}, exp_head());
            end
            do_pop();
         end
      end
   endtask

   task automatic test_errors();
      int e0 = err_cycles;
      send_frame(8'h1C, 1, 0, 11, 0, 0);
      model_frame(8'h1C, 0);
      compared++;
      if (err_cycles - e0 !== 1) begin
         mismatched++;
         $display("[TB] FAIL parity_err_pulse: frame_err cycles %0d expected 1", err_cycles - e0);
      end
      compared++;
      if (key_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL parity_err_no_event: key_valid=%b expected 0", key_valid);
      end
      send_frame(8'hF0, 0, 1, 11, 0, 0);
      model_frame(8'hF0, 0);
      send_frame(8'h1B, 0, 0, 11, 0, 0);
      model_frame(8'h1B, 1);
      compared++;
      if (err_cycles - e0 !== 2) begin
         mismatched++;
         $display("[TB] FAIL stop_err_pulse: frame_err cycles %0d expected 2", err_cycles - e0);
      end
      compared++;
      if ({key_valid, key_release, key_extended, KeyCode} !== exp_head()) begin
         mismatched++;
         $display("[TB] FAIL prefix_cleared_head: got %h expected %h",
                  {key_valid, key_release, key_extended, KeyCode}, exp_head());
      end
      do_pop();
   endtask

   task automatic test_timeout();
      int e0 = err_cycles;
      send_frame(8'h1C, 0, 0, 6, 0, 0);
      wait_cycles(2 * TB_TO);
      model_frame(8'h1C, 0);
      compared++;
      if (err_cycles - e0 !== 1) begin
         mismatched++;
         $display("[TB] FAIL timeout_pulse: frame_err cycles %0d expected 1", err_cycles - e0);
      end
      send_frame(8'h29, 0, 0, 11, 0, 0);
      model_frame(8'h29, 1);
      compared++;
      if ({key_valid, key_release, key_extended, KeyCode} !== exp_head()) begin
         mismatched++;
         $display("[TB] FAIL timeout_recover_head: got %h expected %h",
                  {key_valid, key_release, key_extended, KeyCode}, exp_head());
      end
      do_pop();
   endtask

   task automatic test_mid_reset();
      int e0 = err_cycles;
      send_frame(8'h33, 0, 0, 6, 0, 0);
      Rst = 1'b0;
      tick();
      Rst = 1'b1;
      wait_cycles(TB_TO + 40);
      compared++;
      if (err_cycles - e0 !== 0 || key_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_discard: err cycles %0d key_valid=%b expected 0/0",
                  err_cycles - e0, key_valid);
      end
      send_frame(8'h33, 0, 0, 11, 0, 0);
      model_frame(8'h33, 1);
      compared++;
      if ({key_valid, key_release, key_extended, KeyCode} !== exp_head()) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_recover: got %h expected %h",
                  {key_valid, key_release, key_extended, KeyCode}, exp_head());
      end
      do_pop();
   endtask

   task automatic test_overflow();
      logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
      for (int i = 0; i < 5; i++) begin
         send_frame(codes[i], 0, 0, 11, 0, 0);
         model_frame(codes[i], 1);
      end
      compared++;
      if (overflow !== m_ovf) begin
         mismatched++;
         $display("[TB] FAIL overflow_set: got %b expected %b", overflow, m_ovf);
      end
      for (int i = 0; i < 5; i++) begin
         compared++;
         if ({key_valid, key_release, key_extended, KeyCode} !== exp_head()) begin
            mismatched++;
            $display("[TB] FAIL overflow_drain_%0d: got %h expected %h", i,
                     {key_valid, key_release, key_extended, KeyCode}, exp_head());
         end
         do_pop();
      end
      Rst = 1'b0;
      tick();
      Rst = 1'b1;
      model_reset();
      tick();
      compared++;
      if (overflow !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL overflow_cleared: got %b expected 0", overflow);
      end
      for (int i = 0; i < 4; i++) begin
         send_frame(codes[i], 0, 0, 11, 0, 0);
         model_frame(codes[i], 1);
      end
      // Fifth event arrives while full, together with a pop
      send_frame(8'h2C, 0, 0, 11, 1, 0);
      void'(mq.pop_front());
      model_frame(8'h2C, 1);
      compared++;
      if (overflow !== m_ovf) begin
         mismatched++;
         $display("[TB] FAIL push_pop_full_ovf: got %b expected %b", overflow, m_ovf);
      end
      for (int i = 0; i < 5; i++) begin
         compared++;
         if ({key_valid, key_release, key_extended, KeyCode} !== exp_head()) begin
            mismatched++;
            $display("[TB] FAIL push_pop_full_drain_%0d: got %h expected %h", i,
                     {key_valid, key_release, key_extended, KeyCode}, exp_head());
         end
         do_pop();
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         bad_par, bad_stop;
      int         e0, exp_err;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    b = 8'hE0;
            2:       b = 8'hF0;
            default: b = 8'($urandom);
         endcase
         bad_par  = ($urandom_range(0, 9) == 0);
         bad_stop = !bad_par && ($urandom_range(0, 9) == 0);
         e0 = err_cycles;
         exp_err = (bad_par || bad_stop) ? 1 : 0;
         send_frame(b, bad_par, bad_stop, 11, 0, 0);
         model_frame(b, !(bad_par || bad_stop));
         compared++;
         if ({key_valid, key_release, key_extended, KeyCode} !== exp_head() ||
             err_cycles - e0 !== exp_err) begin
            mismatched++;
            $display("[TB] FAIL random_%0d byte %h: head %h err %0d expected head %h err %0d",
                     n, b, {key_valid, key_release, key_extended, KeyCode}, err_cycles - e0,
                     exp_head(), exp_err);
         end
         if ($urandom_range(0, 2) == 0) do_pop();
      end
      compared++;
      if (overflow !== m_ovf) begin
         mismatched++;
         $display("[TB] FAIL random_overflow: got %b expected %b", overflow, m_ovf);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_basic();
      test_break();
      test_ext_break();
      test_errors();
      test_timeout();
      test_mid_reset();
      test_overflow();
      test_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Upstream input stage for the CPU keyboard path.
- Receives raw PS/2 frames on clk_kb/data_kb and validates start, odd parity and stop bits.
- Folds E0 (extended) and F0 (break) prefixes into single key events and buffers those events in a small FIFO.
- The head entry drives KeyCode, which the CPU load mux consumes as {8'b0,KeyCode}. The CPU acknowledges each event with a one-cycle pop.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two, at least 2.
- TIMEOUT_CYCLES, 50000, Clk cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- Clk  input  1  system clock; all logic is on its rising edge.
- Rst  input  1  synchronous, active-low reset.
- clk_kb  input  1  raw PS/2 clock, asynchronous to Clk.
- data_kb  input  1  raw PS/2 data, asynchronous to Clk.
- pop  input  1  one-cycle strobe that consumes the head event.
- key_valid  output  1  FIFO not empty.
- KeyCode  output  8  scan code of the head event; 0 when empty.
- key_release  output  1  head event was prefixed by F0; 0 when empty.
- key_extended  output  1  head event was prefixed by E0; 0 when empty.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error.

Behaviour:
- Reset:
  - Rst==0 at a Clk edge returns the FSM to IDLE.
  - Clears bit count, shift register, prefix flags, watchdog, FIFO pointers, overflow and frame_err.
  - Sets the synchronizer flops to 1 (idle line level).
  - All outputs are 0 after reset.
  - A reset asserted mid-frame discards the partial frame; no event and no frame_err result.
- Input sampling:
  - Both PS/2 lines pass through 2-flop synchronizers.
  - A falling edge is flagged when the previous synchronized clk_kb was 1 and the current one is 0.
  - The synchronized data bit is sampled in that same cycle.
- Frame FSM (advances on falling edges only):
  - IDLE: if data=0, go to DATA with bit count 0. If data=1, stay in IDLE (spurious edge is ignored, no error).
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: data=1 and odd parity across the 8 data bits plus parity bit means the byte is valid. Otherwise pulse frame_err. Either way, return to IDLE.
- Error handling:
  - Any error clears the prefix flags and produces no event.
- Watchdog:
  - Active only outside IDLE. It counts Clk cycles and clears on every falling edge.
  - On reaching TIMEOUT_CYCLES: return to IDLE, pulse frame_err, clear the prefix flags.
- Prefix decode (on each valid byte):
  - 0xE0: set ext. No event.
  - 0xF0: set brk. No event.
  - Any other value: push {brk, ext, code}, then clear brk and ext. This includes 0xE1, 0xAA and 0xFA, which are passed through as ordinary codes.
- Latency:
  - Let cycle N be the cycle in which the stop-bit falling edge is detected.
  - The byte is validated in N, decoded and written to the FIFO at the end of N+1.
  - key_valid, KeyCode and the flags reflect the event in N+2.
- FIFO:
  - Entries are 10 bits. Outputs show the head combinationally from registered storage.
  - pop while empty: ignored.
  - push while full, no pop: new event dropped, overflow set.
  - push and pop in the same cycle while full: both take effect; count unchanged, no overflow.
  - push and pop in the same cycle while empty: pop ignored, push accepted.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- overflow stays set until reset.

Decomposition:
- Shared package ps2_pkg holds:
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - The frame state encoding: IDLE, DATA, PARITY, STOP.
  - The event field layout: bit 9 release, bit 8 extended, bits 7:0 code.
- One sub-module, key_event_fifo: parameterized synchronous FIFO with push, pop, full, empty, head data and overflow.
- Synchronizer, frame FSM, watchdog and prefix decoder all stay in ps2_key_rx.

Test Plan:
- Frame 0x1C with correct parity -> in N+2: key_valid=1, KeyCode=0x1C, key_release=0, key_extended=0. One pop -> key_valid=0, KeyCode=0.
- Frames F0, 1C -> exactly one event: KeyCode=0x1C, key_release=1, key_extended=0. No event for F0.
- Frames E0, F0, 75 -> one event: KeyCode=0x75, key_extended=1, key_release=1. Next frame 0x74 -> key_extended=0, key_release=0.
- Frame 0x1C with parity bit inverted -> frame_err high exactly 1 cycle, no event. Then F0 with bad stop bit followed by good 0x1B -> event 0x1B with key_release=0 (prefix was cleared).
- Frame stopped after 5 data bits, held idle for TIMEOUT_CYCLES -> one frame_err pulse, FSM in IDLE. Following frame 0x29 -> event 0x29.
- FIFO_DEPTH=4: send 0x15, 0x1D, 0x24, 0x2D, 0x2C with no pops -> overflow=1. Four pops yield 0x15, 0x1D, 0x24, 0x2D, then key_valid=0. Rst=0 for one cycle -> overflow=0. Then pop on the same cycle as push while full -> no overflow.
